// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 1-D convolution sequencer.
//   state_e       sequencer states (IDLE, MAC, OUT)
//   DW_DEF/AW_DEF default sample/weight and accumulator widths
//   k_width()     width of the tap counter for a given kernel length
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 16;

  // Tap index runs 0..taps-1; keep at least one bit for degenerate sizes.
  function automatic int k_width(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/conv1d_seq_mac_step.sv
// mac_step: one combinational multiply-accumulate step.
//   acc_i  AW-bit running sum
//   a_i    DW-bit unsigned sample
//   b_i    DW-bit unsigned weight
//   sum_o  (acc_i + a_i*b_i) mod 2^AW
module mac_step #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic [AW-1:0] acc_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [AW-1:0] sum_o
);

  // Work in the wider of the full product and the accumulator, then wrap.
  localparam int PW = (AW > 2 * DW) ? AW : 2 * DW;

  logic [PW-1:0] prod_s;
  logic [PW-1:0] sum_w_s;

  // Unsigned product and wrapping add.
  always_comb begin
    prod_s  = PW'(a_i) * PW'(b_i);
    sum_w_s = PW'(acc_i) + prod_s;
    sum_o   = sum_w_s[AW-1:0];
  end

endmodule

// File: rtl/conv1d_seq.sv
// conv1d_seq: sliding-window sequencer and accumulator for one 1-D
// convolution channel. Each accepted sample (once the window is full)
// triggers TAPS serial MAC steps and one result on a valid/ready port.
//   clk, rst          clock, synchronous active-high reset
//   w_load/w_idx/w_data  weight slot write (honoured in IDLE only)
//   win_clr           clear window and fill count (IDLE only)
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_ready/out_data  result output handshake
//   busy              sequencer not in IDLE
module conv1d_seq
  import conv_pkg::*;
#(
  parameter int TAPS = 3,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_load,
  input  logic [$clog2(TAPS)-1:0] w_idx,
  input  logic [DW-1:0]           w_data,
  input  logic                    win_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW-1:0]           out_data,
  output logic                    busy
);

  localparam int KW = k_width(TAPS);
  localparam int FW = $clog2(TAPS + 1);
  localparam int IW = $clog2(TAPS);

  state_e        state_q, state_d;
  logic [FW-1:0] fill_q,  fill_d;
  logic [KW-1:0] k_q,     k_d;
  logic [AW-1:0] acc_q,   acc_d;
  logic [AW-1:0] out_q,   out_d;
  logic [DW-1:0] win_q [TAPS];
  logic [DW-1:0] win_d [TAPS];
  logic [DW-1:0] wt_q  [TAPS];
  logic [DW-1:0] wt_d  [TAPS];

  logic [DW-1:0] tap_a_s;
  logic [DW-1:0] tap_b_s;
  logic [AW-1:0] mac_sum_s;

  mac_step #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .acc_i(acc_q),
    .a_i  (tap_a_s),
    .b_i  (tap_b_s),
    .sum_o(mac_sum_s)
  );

  // Select the current tap by comparison so k never indexes past the arrays.
  always_comb begin
    tap_a_s = '0;
    tap_b_s = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k_q == KW'(i)) begin
        tap_a_s = win_q[i];
        tap_b_s = wt_q[i];
      end else begin
        tap_a_s = tap_a_s;
        tap_b_s = tap_b_s;
      end
    end
  end

  // Next-state and handshake outputs of the sequencer.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    k_d       = k_q;
    acc_d     = acc_q;
    out_d     = out_q;
    win_d     = win_q;
    wt_d      = wt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = ~win_clr;
        if (w_load) begin
          // Slots at or above TAPS match no entry and are dropped.
          for (int i = 0; i < TAPS; i++) begin
            if (w_idx == IW'(i)) begin
              wt_d[i] = w_data;
            end else begin
              wt_d[i] = wt_d[i];
            end
          end
        end else begin
          wt_d = wt_q;
        end
        if (win_clr) begin
          for (int i = 0; i < TAPS; i++) begin
            win_d[i] = '0;
          end
          fill_d = '0;
        end else if (in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            win_d[i] = win_q[i-1];
          end
          win_d[0] = in_data;
          if (fill_q < FW'(TAPS - 1)) begin
            fill_d = fill_q + FW'(1);
          end else begin
            // Fill saturates at TAPS; every later sample yields a result.
            if (fill_q != FW'(TAPS)) begin
              fill_d = fill_q + FW'(1);
            end else begin
              fill_d = fill_q;
            end
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
          end
        end else begin
          fill_d = fill_q;
        end
      end
      MAC: begin
        acc_d = mac_sum_s;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(TAPS - 1)) begin
          out_d   = mac_sum_s;
          state_d = OUT;
        end else begin
          state_d = MAC;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign out_data = out_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i] <= '0;
        wt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i] <= win_d[i];
        wt_q[i]  <= wt_d[i];
      end
    end
  end

endmodule
